// File: rtl/sensor_scan_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : sensor_scan_scheduler_pkg
// Brief  : Shared state encoding, default sample width and a clog2 helper for
//          the sensor scan scheduler and its next-channel finder.
// Rev    : 1.0  initial release
// ============================================================================
package sensor_scan_scheduler_pkg;

  localparam int SEN_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_START    = 3'd3,
    ST_WAIT     = 3'd4,
    ST_DISPATCH = 3'd5,
    ST_NEXT     = 3'd6
  } scan_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit so that
  // counters and selects always have a legal width.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_scan_scheduler_rr_next_channel.sv
`default_nettype none
// ============================================================================
// Module : rr_next_channel
// Brief  : Combinational round-robin finder. Returns the first set bit of
//          mask at or after ptr (INCLUSIVE=1) or strictly after ptr
//          (INCLUSIVE=0), searching with wrap-around.
// Ports  : mask     in  N_CH   candidate channels
//          ptr      in  PTR_W  search origin
//          next_idx out PTR_W  index found (ptr when none)
//          wrapped  out 1      search wrapped to an index at/below ptr
//          none     out 1      mask is empty
// Rev    : 1.0  initial release
// ============================================================================
module rr_next_channel #(
  parameter int N_CH      = 4,
  parameter int PTR_W     = 2,
  parameter bit INCLUSIVE = 1'b0
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] next_idx,
  output logic             wrapped,
  output logic             none
);

  localparam int OFF = INCLUSIVE ? 0 : 1;

  // Doubled mask rotated so that bit j corresponds to channel (ptr+j) mod N.
  logic [2*N_CH-1:0] rot;
  logic              found;
  int                sum;

  always_comb begin
    rot      = {mask, mask} >> ptr;
    next_idx = ptr;
    found    = 1'b0;
    sum      = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && (|(rot & ((2*N_CH)'(1) << (k + OFF))))) begin
        found = 1'b1;
        sum   = int'(ptr) + k + OFF;
        if (sum >= N_CH) sum = sum - N_CH;
        next_idx = PTR_W'(sum);
      end
    end
    none    = !found;
    wrapped = found && (INCLUSIVE ? (next_idx < ptr) : (next_idx <= ptr));
  end

endmodule
`default_nettype wire

// File: rtl/sensor_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module : sensor_scan_scheduler
// Brief  : Round-robin sequencer for one shared ADC across N_CH protection
//          channels: mux select, settle, conversion handshake, per-channel
//          sample latch and one-hot enable pulse, plus aggregated trip flag.
// Ports  : clk_16ms        in  system tick clock
//          rst             in  synchronous active-high reset
//          run             in  scan continuously while high
//          ch_mask         in  channels included in the scan
//          adc_data        in  conversion result (valid with adc_done)
//          adc_done        in  conversion-complete strobe
//          err_clr         in  clears adc_timeout_err
//          relay_in        in  relay outputs of the channel FSMs
//          mux_sel         out analog mux select
//          adc_start       out 1-cycle conversion request
//          sen_bus         out latched sample per channel, ch k at [k*SEN_W +: SEN_W]
//          ch_enable       out one-hot 1-cycle enable to channel FSMs
//          scan_done       out pulse when the pointer wraps
//          adc_timeout_err out sticky ADC timeout flag
//          any_trip        out registered OR of masked relays
// Rev    : 1.0  initial release
// ============================================================================
module sensor_scan_scheduler
  import sensor_scan_scheduler_pkg::*;
#(
  parameter  int N_CH        = 4,
  parameter  int SEN_W       = SEN_W_DEFAULT,
  parameter  int SETTLE_CYC  = 2,
  parameter  int ADC_TIMEOUT = 8,
  localparam int PTR_W       = clog2_min1(N_CH)
) (
  input  logic                  clk_16ms,
  input  logic                  rst,
  input  logic                  run,
  input  logic [N_CH-1:0]       ch_mask,
  input  logic [SEN_W-1:0]      adc_data,
  input  logic                  adc_done,
  input  logic                  err_clr,
  input  logic [N_CH-1:0]       relay_in,
  output logic [PTR_W-1:0]      mux_sel,
  output logic                  adc_start,
  output logic [N_CH*SEN_W-1:0] sen_bus,
  output logic [N_CH-1:0]       ch_enable,
  output logic                  scan_done,
  output logic                  adc_timeout_err,
  output logic                  any_trip
);

  localparam int                SET_W       = clog2_min1(SETTLE_CYC);
  localparam int                TMO_W       = clog2_min1(ADC_TIMEOUT);
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(ADC_TIMEOUT - 1);

  scan_state_e      state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] mux_sel_q, mux_sel_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [TMO_W-1:0] wait_q, wait_d;
  logic [SEN_W-1:0] sen_q [N_CH];
  logic [SEN_W-1:0] sen_d [N_CH];
  logic             err_q, err_d;
  logic             any_trip_q, any_trip_d;
  logic             timeout;

  logic [PTR_W-1:0] incl_idx, excl_idx;
  logic             incl_wrapped, excl_wrapped;
  logic             incl_none, excl_none;

  // IDLE resumes at the current pointer if it is still masked.
  rr_next_channel #(.N_CH(N_CH), .PTR_W(PTR_W), .INCLUSIVE(1'b1)) u_find_incl (
    .mask     (ch_mask),
    .ptr      (ptr_q),
    .next_idx (incl_idx),
    .wrapped  (incl_wrapped),
    .none     (incl_none)
  );

  // NEXT always moves past the channel just serviced.
  rr_next_channel #(.N_CH(N_CH), .PTR_W(PTR_W), .INCLUSIVE(1'b0)) u_find_excl (
    .mask     (ch_mask),
    .ptr      (ptr_q),
    .next_idx (excl_idx),
    .wrapped  (excl_wrapped),
    .none     (excl_none)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mux_sel_d  = mux_sel_q;
    settle_d   = settle_q;
    wait_d     = wait_q;
    sen_d      = sen_q;
    err_d      = err_q;
    any_trip_d = |(relay_in & ch_mask);
    timeout    = 1'b0;
    adc_start  = 1'b0;
    ch_enable  = '0;
    scan_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run && !incl_none) begin
          ptr_d   = incl_idx;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        mux_sel_d = ptr_q;
        settle_d  = SETTLE_LOAD;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_START;
        else                settle_d = settle_q - SET_W'(1);
      end
      ST_START: begin
        adc_start = 1'b1;
        wait_d    = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // A done strobe on the last allowed cycle still counts as success.
        if (adc_done) begin
          sen_d[ptr_q] = adc_data;
          state_d      = ST_DISPATCH;
        end else if (wait_q == TMO_LAST) begin
          timeout = 1'b1;
          state_d = ST_NEXT;
        end else begin
          wait_d = wait_q + TMO_W'(1);
        end
      end
      ST_DISPATCH: begin
        ch_enable = N_CH'(1) << ptr_q;
        state_d   = ST_NEXT;
      end
      ST_NEXT: begin
        if (!excl_none) begin
          ptr_d     = excl_idx;
          scan_done = excl_wrapped;
        end
        if (!run || excl_none) state_d = ST_IDLE;
        else                   state_d = ST_SELECT;
      end
      default: state_d = ST_IDLE;
    endcase

    // Set has priority over clear.
    if (err_clr) err_d = 1'b0;
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk_16ms) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      mux_sel_q  <= '0;
      settle_q   <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      any_trip_q <= 1'b0;
      for (int k = 0; k < N_CH; k++) sen_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mux_sel_q  <= mux_sel_d;
      settle_q   <= settle_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      any_trip_q <= any_trip_d;
      for (int k = 0; k < N_CH; k++) sen_q[k] <= sen_d[k];
    end
  end

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_pack
      assign sen_bus[g*SEN_W +: SEN_W] = sen_q[g];
    end
  endgenerate

  assign mux_sel         = mux_sel_q;
  assign adc_timeout_err = err_q;
  assign any_trip        = any_trip_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_sensor_scan_scheduler
// Brief  : Self-checking bench for sensor_scan_scheduler with a
//          transaction-level model of channel order, samples and flags.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sensor_scan_scheduler;

  localparam int N_CH   = 4;
  localparam int SEN_W  = 16;
  localparam int SETTLE = 2;
  localparam int TMO    = 8;

  logic        clk_16ms = 1'b0;
  logic        rst, run, adc_done, err_clr;
  logic [3:0]  ch_mask, relay_in;
  logic [15:0] adc_data;
  logic [1:0]  mux_sel;
  logic        adc_start, scan_done, adc_timeout_err, any_trip;
  logic [63:0] sen_bus;
  logic [3:0]  ch_enable;

  sensor_scan_scheduler #(
    .N_CH(N_CH), .SEN_W(SEN_W), .SETTLE_CYC(SETTLE), .ADC_TIMEOUT(TMO)
  ) dut (
    .clk_16ms        (clk_16ms),
    .rst             (rst),
    .run             (run),
    .ch_mask         (ch_mask),
    .adc_data        (adc_data),
    .adc_done        (adc_done),
    .err_clr         (err_clr),
    .relay_in        (relay_in),
    .mux_sel         (mux_sel),
    .adc_start       (adc_start),
    .sen_bus         (sen_bus),
    .ch_enable       (ch_enable),
    .scan_done       (scan_done),
    .adc_timeout_err (adc_timeout_err),
    .any_trip        (any_trip)
  );

  always #5 clk_16ms = ~clk_16ms;

  int          n_total = 0;
  int          n_pass  = 0;
  int          cyc     = 0;
  logic [15:0] exp_slot [4];
  int          exp_ptr;
  logic        exp_err;
  bit          have_prev;
  int          prev_delay;
  int          last_start;

  task automatic tick();
    @(posedge clk_16ms);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] exp_bus();
    logic [63:0] b;
    b = '0;
    for (int k = 0; k < 4; k++) b = b | (64'(exp_slot[k]) << (16 * k));
    return b;
  endfunction

  function automatic bit has(input logic [3:0] m, input int k);
    return ((m >> k) & 4'd1) != 4'd0;
  endfunction

  // Smallest masked channel above ch, else smallest masked overall.
  function automatic int next_after(input int ch, input logic [3:0] m);
    for (int k = ch + 1; k < 4; k++) if (has(m, k)) return k;
    for (int k = 0; k < 4; k++) if (has(m, k)) return k;
    return -1;
  endfunction

  // Smallest masked channel at or above ch, else smallest masked overall.
  function automatic int first_from(input int ch, input logic [3:0] m);
    for (int k = ch; k < 4; k++) if (has(m, k)) return k;
    for (int k = 0; k < 4; k++) if (has(m, k)) return k;
    return -1;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_mux"},   64'(mux_sel), 0);
    check({tag, "_start"}, 64'(adc_start), 0);
    check({tag, "_bus"},   sen_bus, 0);
    check({tag, "_en"},    64'(ch_enable), 0);
    check({tag, "_done"},  64'(scan_done), 0);
    check({tag, "_err"},   64'(adc_timeout_err), 0);
    check({tag, "_trip"},  64'(any_trip), 0);
  endtask

  // One channel service. delay = WAIT cycle carrying adc_done (0 = never).
  task automatic do_channel(input int delay, input logic [15:0] data,
                            input logic [3:0] new_mask, input bit chg_mask,
                            input bit drop_run, input bit clr_at_tmo);
    int ch;
    int nxt;
    bit got;
    ch  = exp_ptr;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (adc_start === 1'b1) begin
        got = 1'b1;
        break;
      end
      check("en_before_start", 64'(ch_enable), 0);
      if (i == 1 && drop_run) run = 1'b0;
      tick();
    end
    check("start_seen", 64'(got), 1);
    if (!got) return;
    check("mux_sel", 64'(mux_sel), 64'(ch));
    check("start_no_en", 64'(ch_enable), 0);
    if (have_prev)
      check("period", 64'(cyc - last_start),
            64'(prev_delay == 0 ? TMO + 3 + SETTLE : prev_delay + 4 + SETTLE));
    last_start = cyc;
    prev_delay = delay;
    have_prev  = 1'b1;
    if (chg_mask) ch_mask = new_mask;
    tick();
    if (delay > 0) begin
      for (int w = 1; w < delay; w++) begin
        check("wait_no_en", 64'(ch_enable), 0);
        tick();
      end
      adc_data = data;
      adc_done = 1'b1;
      tick();
      adc_done = 1'b0;
      adc_data = 16'($urandom);
      exp_slot[ch] = data;
      check("enable", 64'(ch_enable), 64'(4'b0001 << ch));
      check("disp_no_start", 64'(adc_start), 0);
      check("disp_no_done", 64'(scan_done), 0);
      check("sen_bus", sen_bus, exp_bus());
      tick();
    end else begin
      for (int w = 1; w < TMO; w++) begin
        check("wait_no_en", 64'(ch_enable), 0);
        tick();
      end
      if (clr_at_tmo) err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      exp_err = 1'b1;
      check("tmo_no_en", 64'(ch_enable), 0);
      check("tmo_bus_kept", sen_bus, exp_bus());
    end
    nxt = next_after(ch, ch_mask);
    check("scan_done", 64'(scan_done), 64'(nxt <= ch));
    check("err_flag", 64'(adc_timeout_err), 64'(exp_err));
    exp_ptr = nxt;
    tick();
    if (!run) have_prev = 1'b0;
  endtask

  initial begin
    bit got;
    logic [3:0] rm, rr;
    rst = 1'b1; run = 1'b0; ch_mask = '0; adc_data = '0; adc_done = 1'b0;
    err_clr = 1'b0; relay_in = '0;
    for (int k = 0; k < 4; k++) exp_slot[k] = '0;
    exp_ptr = 0; exp_err = 1'b0; have_prev = 1'b0; prev_delay = 0; last_start = 0;

    repeat (3) tick();
    check_reset("rst");
    rst = 1'b0;
    tick();
    check_reset("post_rst");

    // Full mask, fixed 1-cycle conversion, data 100+ch.
    ch_mask = 4'b1111;
    run     = 1'b1;
    for (int n = 0; n < 5; n++) do_channel(1, 16'(100 + exp_ptr), 4'h0, 1'b0, 1'b0, 1'b0);
    check("pass1_bus", sen_bus, {16'd103, 16'd102, 16'd101, 16'd100});

    // Mid-channel mask change to 1010, then random delays.
    do_channel($urandom_range(1, 3), 16'($urandom), 4'b1010, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) do_channel($urandom_range(1, 3), 16'($urandom), 4'h0, 1'b0, 1'b0, 1'b0);
    do_channel($urandom_range(1, 3), 16'($urandom), 4'b1111, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 6 && exp_ptr != 2; n++)
      do_channel($urandom_range(1, 3), 16'($urandom), 4'h0, 1'b0, 1'b0, 1'b0);

    // ADC never answers on ch2; err_clr coincides with the timeout.
    check("at_ch2", 64'(exp_ptr), 2);
    do_channel(0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 6 && exp_ptr != 1; n++)
      do_channel($urandom_range(1, 3), 16'($urandom), 4'h0, 1'b0, 1'b0, 1'b0);

    // Drop run during SETTLE of ch1; channel completes then scanner idles.
    check("at_ch1", 64'(exp_ptr), 1);
    do_channel($urandom_range(1, 3), 16'($urandom), 4'h0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      check("idle_no_start", 64'(adc_start), 0);
      tick();
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 1'b0;
    check("err_cleared", 64'(adc_timeout_err), 0);
    run     = 1'b1;
    exp_ptr = first_from(exp_ptr, ch_mask);
    check("resume_ch2", 64'(exp_ptr), 2);
    do_channel($urandom_range(1, 3), 16'($urandom), 4'h0, 1'b0, 1'b0, 1'b0);

    // Random masks applied mid-channel.
    for (int n = 0; n < 12; n++) begin
      rm = 4'($urandom_range(1, 15));
      do_channel($urandom_range(1, 3), 16'($urandom), rm, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Reset during WAIT, then a stray adc_done.
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (adc_start === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("rst_start_seen", 64'(got), 1);
    tick();
    rst = 1'b1;
    run = 1'b0;
    tick();
    rst      = 1'b0;
    adc_done = 1'b1;
    adc_data = 16'hBEEF;
    tick();
    adc_done = 1'b0;
    check_reset("wait_rst");
    for (int k = 0; k < 4; k++) exp_slot[k] = '0;
    exp_ptr = 0; exp_err = 1'b0; have_prev = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("rst_idle_start", 64'(adc_start), 0);
      check("rst_idle_bus", sen_bus, 0);
    end

    // any_trip while idle.
    relay_in = 4'b0100;
    ch_mask  = 4'b1011;
    tick();
    check("trip_masked", 64'(any_trip), 0);
    ch_mask = 4'b1111;
    check("trip_lag", 64'(any_trip), 0);
    tick();
    check("trip_set", 64'(any_trip), 1);
    for (int n = 0; n < 8; n++) begin
      rr = 4'($urandom);
      rm = 4'($urandom);
      relay_in = rr;
      ch_mask  = rm;
      tick();
      check("trip_rand", 64'(any_trip), 64'(|(rr & rm)));
    end
    relay_in = '0;

    // From reset with mask 1010: slots 0 and 2 stay zero.
    ch_mask = 4'b1010;
    run     = 1'b1;
    exp_ptr = first_from(0, ch_mask);
    for (int n = 0; n < 4; n++) do_channel($urandom_range(1, 3), 16'($urandom), 4'h0, 1'b0, 1'b0, 1'b0);
    check("mask1010_slot0", 64'(sen_bus[15:0]), 0);
    check("mask1010_slot2", 64'(sen_bus[47:32]), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
